// File: rtl/serv_progbuf_resp_pkg.sv
// Shared constants for the debug program-buffer ibus responder.
package serv_progbuf_resp_pkg;

    localparam logic [31:0] PB_EBREAK_INSN = 32'h0010_0073;

    // The address window always spans 16 words, whatever DEPTH is loaded.
    localparam int unsigned WIN_WORDS = 16;
    localparam int unsigned IDX_W     = $clog2(WIN_WORDS);
    localparam int unsigned WIN_LSB   = $clog2(WIN_WORDS * 4);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/serv_progbuf_resp_mem.sv
// Program-buffer word storage: DEPTH x 32 registers, one write port, one
// combinational read port that returns the EBREAK word past DEPTH.
module serv_progbuf_mem
    import serv_progbuf_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter logic [31:0] EBREAK_INSN = PB_EBREAK_INSN
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [31:0]      i_wdat,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [31:0]      o_rdat
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= EBREAK_INSN;
            end
        end else if (i_we) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i_widx == IDX_W'(i)) begin
                    mem_q[i] <= i_wdat;
                end
            end
        end
    end

    always_comb begin
        o_rdat = EBREAK_INSN;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_ridx == IDX_W'(i)) begin
                o_rdat = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/serv_progbuf_resp.sv
// Wishbone ibus responder serving the debug program buffer; a fetch that
// returns EBREAK ends the run and pulses o_done.
module serv_progbuf_resp
    import serv_progbuf_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter logic [31:0] BASE        = 32'h0000_0800,
    parameter logic [31:0] EBREAK_INSN = PB_EBREAK_INSN
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    output logic        o_ibus_hit,
    input  logic        i_pb_we,
    input  logic [3:0]  i_pb_idx,
    input  logic [31:0] i_pb_dat,
    input  logic        i_go,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pb_err,
    output logic [7:0]  o_fetch_cnt
);

    logic [1:0]  state_q, state_d;
    logic [31:0] rdt_q, rdt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        hit;
    logic        latch;
    logic        in_resp;
    logic        term;
    logic        go_ok;
    logic        wr_ok;
    logic [31:0] mem_rdat;
    logic        unused_adr;

    assign unused_adr = ^i_ibus_adr[1:0];

    assign hit     = (i_ibus_adr[31:WIN_LSB] == BASE[31:WIN_LSB]);
    assign latch   = (state_q == ST_IDLE) & i_ibus_cyc & hit & busy_q;
    assign in_resp = (state_q == ST_RESP);
    // Only a live run is terminated; a response left over after abort is not.
    assign term    = in_resp & busy_q & (rdt_q == EBREAK_INSN);
    assign go_ok   = i_go & ~busy_q & ~i_abort;
    assign wr_ok   = i_pb_we & ~busy_q & (32'(i_pb_idx) < DEPTH);

    serv_progbuf_mem #(
        .DEPTH       (DEPTH),
        .EBREAK_INSN (EBREAK_INSN)
    ) u_mem (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_we   (wr_ok),
        .i_widx (i_pb_idx),
        .i_wdat (i_pb_dat),
        .i_ridx (i_ibus_adr[WIN_LSB-1:2]),
        .o_rdat (mem_rdat)
    );

    always_comb begin
        state_d = state_q;
        rdt_d   = rdt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (latch) begin
                    state_d = ST_RESP;
                    rdt_d   = mem_rdat;
                end
            end
            ST_RESP: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_d = term & ~i_abort;
        err_d  = (go_ok ? 1'b0 : err_q) | (i_pb_we & ~wr_ok);

        if (go_ok) begin
            cnt_d = '0;
        end else if (in_resp && cnt_q != '1) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (i_abort) begin
            busy_d = 1'b0;
        end else if (go_ok) begin
            busy_d = 1'b1;
        end else if (term) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            rdt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdt_q   <= rdt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ibus_rdt  = rdt_q;
    assign o_ibus_ack  = in_resp;
    assign o_ibus_hit  = hit;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pb_err    = err_q;
    assign o_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_serv_progbuf_resp.sv
// Bench for serv_progbuf_resp: directed scenarios with literal expectations,
// then randomized host/ibus traffic checked every cycle against a model.
module tb_serv_progbuf_resp;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0800;
    localparam logic [31:0] EB    = 32'h0010_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_ibus_adr = '0;
    logic        i_ibus_cyc = 1'b0;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic        o_ibus_hit;
    logic        i_pb_we = 1'b0;
    logic [3:0]  i_pb_idx = '0;
    logic [31:0] i_pb_dat = '0;
    logic        i_go = 1'b0;
    logic        i_abort = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_pb_err;
    logic [7:0]  o_fetch_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    serv_progbuf_resp #(
        .DEPTH       (DEPTH),
        .BASE        (BASE),
        .EBREAK_INSN (EB)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_ibus_adr  (i_ibus_adr),
        .i_ibus_cyc  (i_ibus_cyc),
        .o_ibus_rdt  (o_ibus_rdt),
        .o_ibus_ack  (o_ibus_ack),
        .o_ibus_hit  (o_ibus_hit),
        .i_pb_we     (i_pb_we),
        .i_pb_idx    (i_pb_idx),
        .i_pb_dat    (i_pb_dat),
        .i_go        (i_go),
        .i_abort     (i_abort),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pb_err    (o_pb_err),
        .o_fetch_cnt (o_fetch_cnt)
    );

    // Reference model: what each output must be in the current cycle.
    logic [31:0] m_buf [16];
    bit          m_busy, m_done, m_err, m_ack;
    logic [31:0] m_rdt;
    int          m_cnt;
    int          m_cool;

    function automatic bit in_win(logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd64);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_buf[i] = EB;
        m_busy = 0; m_done = 0; m_err = 0; m_ack = 0;
        m_rdt = '0; m_cnt = 0; m_cool = 0;
    endtask

    task automatic m_step();
        bit was_ack, busy0, ends, go_ok;
        int w;
        if (i_rst) begin
            m_reset();
            return;
        end
        was_ack = m_ack;
        busy0   = m_busy;
        ends    = was_ack && busy0 && (m_rdt == EB);
        go_ok   = i_go && !busy0 && !i_abort;
        if (was_ack) begin
            m_ack  = 0;
            m_cool = 1;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (i_ibus_cyc && in_win(i_ibus_adr) && busy0) begin
            w = int'((i_ibus_adr - BASE) >> 2);
            m_ack = 1;
            m_rdt = (w < int'(DEPTH)) ? m_buf[w] : EB;
        end
        m_done = ends && !i_abort;
        if (i_pb_we && !busy0 && int'(i_pb_idx) < int'(DEPTH)) m_buf[i_pb_idx] = i_pb_dat;
        m_err = (go_ok ? 1'b0 : m_err) || (i_pb_we && (busy0 || int'(i_pb_idx) >= int'(DEPTH)));
        if (go_ok) m_cnt = 0;
        else if (was_ack && m_cnt < 255) m_cnt++;
        m_busy = i_abort ? 1'b0 : go_ok ? 1'b1 : ends ? 1'b0 : busy0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack",  32'(o_ibus_ack), 32'(m_ack));
            if (m_ack) chk("rdt", o_ibus_rdt, m_rdt);
            chk("hit",  32'(o_ibus_hit), 32'(in_win(i_ibus_adr)));
            chk("busy", 32'(o_busy),     32'(m_busy));
            chk("done", 32'(o_done),     32'(m_done));
            chk("err",  32'(o_pb_err),   32'(m_err));
            chk("cnt",  32'(o_fetch_cnt), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic hwrite(int idx, logic [31:0] d);
        i_pb_we = 1; i_pb_idx = 4'(idx); i_pb_dat = d;
        tick();
        i_pb_we = 0;
    endtask

    task automatic start();
        i_go = 1;
        tick();
        i_go = 0;
    endtask

    task automatic do_abort();
        i_abort = 1;
        tick();
        i_abort = 0;
    endtask

    task automatic fetch(logic [31:0] a, string name, logic [31:0] exp, output bit done_seen);
        bit          got;
        logic [31:0] w;
        got = 0; w = '0;
        i_ibus_cyc = 1; i_ibus_adr = a;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if (o_ibus_ack) begin
                got = 1;
                w = o_ibus_rdt;
            end
        end
        i_ibus_cyc = 0;
        tick();
        done_seen = o_done;
        chk({name, "_acked"}, 32'(got), 32'd1);
        chk(name, w, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit d;
        bit prev_ack;
        int hold;

        m_reset();
        chk_en = 1;
        tick(); tick();
        i_rst = 0;
        tick();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ack",  32'(o_ibus_ack), 32'd0);
        chk("rst_rdt",  o_ibus_rdt, 32'd0);
        chk("rst_cnt",  32'(o_fetch_cnt), 32'd0);
        chk("rst_err",  32'(o_pb_err), 32'd0);

        // Two-word program terminated by a loaded EBREAK.
        hwrite(0, NOP);
        hwrite(1, EB);
        start();
        chk("go_busy", 32'(o_busy), 32'd1);
        fetch(BASE, "t1_w0", NOP, d);
        chk("t1_no_done", 32'(d), 32'd0);
        fetch(BASE + 4, "t1_w1", EB, d);
        chk("t1_done", 32'(d), 32'd1);
        chk("t1_busy", 32'(o_busy), 32'd0);
        chk("t1_cnt",  32'(o_fetch_cnt), 32'd2);

        // Four NOPs then the implicit EBREAK past DEPTH.
        for (int i = 0; i < 4; i++) hwrite(i, NOP);
        start();
        for (int i = 0; i < 4; i++) fetch(BASE + 32'(4 * i), "t2_nop", NOP, d);
        fetch(BASE + 32'h10, "t2_past", EB, d);
        chk("t2_done", 32'(d), 32'd1);
        chk("t2_cnt",  32'(o_fetch_cnt), 32'd5);

        // Rejected host writes.
        start();
        hwrite(2, 32'hDEAD_BEEF);
        chk("t3_err_busy", 32'(o_pb_err), 32'd1);
        do_abort();
        chk("t3_abort_busy", 32'(o_busy), 32'd0);
        start();
        chk("t3_go_clr", 32'(o_pb_err), 32'd0);
        do_abort();
        hwrite(5, 32'h1234_5678);
        chk("t3_err_idx", 32'(o_pb_err), 32'd1);
        start();
        chk("t3_go_clr2", 32'(o_pb_err), 32'd0);
        fetch(BASE + 8, "t3_unchanged", NOP, d);
        do_abort();

        // Miss while busy is never acked.
        start();
        i_ibus_cyc = 1; i_ibus_adr = 32'h0000_1000;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t4_hit", 32'(o_ibus_hit), 32'd0);
            chk("t4_ack", 32'(o_ibus_ack), 32'd0);
        end
        i_ibus_cyc = 0;
        tick();
        chk("t4_cnt", 32'(o_fetch_cnt), 32'd0);

        // Abort in the latch cycle: ack still arrives, no done.
        i_ibus_cyc = 1; i_ibus_adr = BASE; i_abort = 1;
        tick();
        i_abort = 0; i_ibus_cyc = 0;
        chk("t5_ack",  32'(o_ibus_ack), 32'd1);
        chk("t5_rdt",  o_ibus_rdt, NOP);
        chk("t5_busy", 32'(o_busy), 32'd0);
        tick();
        chk("t5_done", 32'(o_done), 32'd0);

        // Reset during the response cycle.
        tick();
        start();
        i_ibus_cyc = 1; i_ibus_adr = BASE;
        tick();
        chk("t6_ack_pre", 32'(o_ibus_ack), 32'd1);
        i_rst = 1;
        m_reset();
        #1;
        chk("t6_ack_rst", 32'(o_ibus_ack), 32'd0);
        i_ibus_cyc = 0;
        tick();
        i_rst = 0;
        tick();
        chk("t6_busy", 32'(o_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            start();
            fetch(BASE + 32'(4 * i), "t6_word", EB, d);
            chk("t6_done", 32'(d), 32'd1);
        end

        // Randomized traffic.
        prev_ack = 0;
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            i_pb_we  = ($urandom % 8 == 0);
            i_pb_idx = 4'(($urandom % 4 == 0) ? $urandom % 16 : $urandom % DEPTH);
            i_pb_dat = ($urandom % 4 == 0) ? EB : $urandom;
            i_go     = ($urandom % 24 == 0);
            i_abort  = ($urandom % 150 == 0);
            if (i_rst) begin
                i_rst = 0;
            end else if ($urandom % 800 == 0) begin
                i_rst = 1;
                m_reset();
            end
            if (i_ibus_cyc) begin
                hold++;
                if (prev_ack || hold > 8) i_ibus_cyc = 0;
            end else if ($urandom % 2 == 0) begin
                i_ibus_cyc = 1;
                hold = 0;
                i_ibus_adr = ($urandom % 10 == 0) ? $urandom
                           : BASE + 32'(4 * ($urandom % 20)) + 32'($urandom % 4);
            end
            prev_ack = m_ack;
            tick();
        end

        i_pb_we = 0; i_go = 0; i_abort = 0; i_ibus_cyc = 0;
        tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
